// File: rtl/decimation_filter.sv
// Decimate-by-16 sigma-delta back end: CIC4 (R=4) -> 3-tap compensation FIR -> two half-band
// decimate-by-2 stages. All arithmetic is exact; every stage is sized for its worst-case gain.
module decimation_filter #(
    parameter int INPUT_WIDTH  = 5,
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [INPUT_WIDTH-1:0]  in_data,
    output logic                           out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] out_data
);
    localparam int W_CIC = INPUT_WIDTH + 8;   // CIC gain 256
    localparam int W_FIR = W_CIC + 4;         // |taps| sum 12
    localparam int W_HB1 = W_FIR + 6;         // |taps| sum 36
    localparam int W_HB2 = W_HB1 + 6;

    // ---------------- CIC integrators and decimation phase ----------------
    logic signed [W_CIC-1:0] r_int1, r_int2, r_int3, r_int4;
    logic signed [W_CIC-1:0] w_in_ext, w_int1, w_int2, w_int3, w_int4;
    logic [1:0]              r_cic_phase;
    logic                    r_comb_go;

    // Integrators chain combinationally, so after sample n r_int4 is the plain 4-fold running sum.
    // Modular wrap in W_CIC bits is harmless: the combs difference it away exactly.
    assign w_in_ext = W_CIC'(in_data);
    assign w_int1   = r_int1 + w_in_ext;
    assign w_int2   = r_int2 + w_int1;
    assign w_int3   = r_int3 + w_int2;
    assign w_int4   = r_int4 + w_int3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int1      <= '0;
            r_int2      <= '0;
            r_int3      <= '0;
            r_int4      <= '0;
            r_cic_phase <= '0;
            r_comb_go   <= 1'b0;
        end else begin
            r_comb_go <= 1'b0;
            if (in_valid) begin
                r_int1      <= w_int1;
                r_int2      <= w_int2;
                r_int3      <= w_int3;
                r_int4      <= w_int4;
                r_cic_phase <= r_cic_phase + 2'd1;
                r_comb_go   <= (r_cic_phase == 2'd3);
            end
        end
    end

    // ---------------- CIC combs (one cycle) ----------------
    logic signed [W_CIC-1:0] r_comb_dl [4];
    logic signed [W_CIC-1:0] w_c1, w_c2, w_c3, w_c4;
    logic signed [W_CIC-1:0] r_y1;
    logic                    r_y1_valid;

    assign w_c1 = r_int4 - r_comb_dl[0];
    assign w_c2 = w_c1   - r_comb_dl[1];
    assign w_c3 = w_c2   - r_comb_dl[2];
    assign w_c4 = w_c3   - r_comb_dl[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay lines are state, not storage, so they are cleared on reset like any
            // other register; otherwise a mid-stream reset would leak old history into new outputs.
            for (int i = 0; i < 4; i++) r_comb_dl[i] <= '0;
            r_y1       <= '0;
            r_y1_valid <= 1'b0;
        end else begin
            r_y1_valid <= r_comb_go;
            if (r_comb_go) begin
                r_comb_dl[0] <= r_int4;
                r_comb_dl[1] <= w_c1;
                r_comb_dl[2] <= w_c2;
                r_comb_dl[3] <= w_c3;
                r_y1         <= w_c4;
            end
        end
    end

    // ---------------- Compensation FIR: -1, 10, -1 ----------------
    logic signed [W_CIC-1:0] r_fir_d1, r_fir_d2;
    logic signed [W_FIR-1:0] w_fir_x0, w_fir_x1, w_fir_x2, w_fir;
    logic signed [W_FIR-1:0] r_y2;
    logic                    r_y2_valid;

    assign w_fir_x0 = W_FIR'(r_y1);
    assign w_fir_x1 = W_FIR'(r_fir_d1);
    assign w_fir_x2 = W_FIR'(r_fir_d2);
    assign w_fir    = -w_fir_x0 + W_FIR'(10) * w_fir_x1 - w_fir_x2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fir_d1   <= '0;
            r_fir_d2   <= '0;
            r_y2       <= '0;
            r_y2_valid <= 1'b0;
        end else begin
            r_y2_valid <= r_y1_valid;
            if (r_y1_valid) begin
                r_fir_d1 <= r_y1;
                r_fir_d2 <= r_fir_d1;
                r_y2     <= w_fir;
            end
        end
    end

    // ---------------- Half-band 1: -1, 0, 9, 16, 9, 0, -1 ; keep odd-numbered inputs ----------------
    logic signed [W_FIR-1:0] r_hb1_dl [6];   // [i] holds x[n-1-i]
    logic signed [W_HB1-1:0] w_hb1_x0, w_hb1_x2, w_hb1_x3, w_hb1_x4, w_hb1_x6, w_hb1;
    logic                    r_hb1_phase;
    logic signed [W_HB1-1:0] r_y3;
    logic                    r_y3_valid;

    assign w_hb1_x0 = W_HB1'(r_y2);
    assign w_hb1_x2 = W_HB1'(r_hb1_dl[1]);
    assign w_hb1_x3 = W_HB1'(r_hb1_dl[2]);
    assign w_hb1_x4 = W_HB1'(r_hb1_dl[3]);
    assign w_hb1_x6 = W_HB1'(r_hb1_dl[5]);
    assign w_hb1    = -w_hb1_x0 + W_HB1'(9) * w_hb1_x2 + (w_hb1_x3 <<< 4)
                      + W_HB1'(9) * w_hb1_x4 - w_hb1_x6;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) r_hb1_dl[i] <= '0;
            r_hb1_phase <= 1'b0;
            r_y3        <= '0;
            r_y3_valid  <= 1'b0;
        end else begin
            r_y3_valid <= 1'b0;
            if (r_y2_valid) begin
                r_hb1_dl[0] <= r_y2;
                for (int i = 1; i < 6; i++) r_hb1_dl[i] <= r_hb1_dl[i-1];
                r_hb1_phase <= ~r_hb1_phase;
                if (r_hb1_phase) begin
                    r_y3       <= w_hb1;
                    r_y3_valid <= 1'b1;
                end
            end
        end
    end

    // ---------------- Half-band 2 feeding the output register ----------------
    logic signed [W_HB1-1:0]        r_hb2_dl [6];
    logic signed [W_HB2-1:0]        w_hb2_x0, w_hb2_x2, w_hb2_x3, w_hb2_x4, w_hb2_x6, w_hb2;
    logic                           r_hb2_phase;
    logic signed [OUTPUT_WIDTH-1:0] r_out_data;
    logic                           r_out_valid;

    assign w_hb2_x0 = W_HB2'(r_y3);
    assign w_hb2_x2 = W_HB2'(r_hb2_dl[1]);
    assign w_hb2_x3 = W_HB2'(r_hb2_dl[2]);
    assign w_hb2_x4 = W_HB2'(r_hb2_dl[3]);
    assign w_hb2_x6 = W_HB2'(r_hb2_dl[5]);
    assign w_hb2    = -w_hb2_x0 + W_HB2'(9) * w_hb2_x2 + (w_hb2_x3 <<< 4)
                      + W_HB2'(9) * w_hb2_x4 - w_hb2_x6;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) r_hb2_dl[i] <= '0;
            r_hb2_phase <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_y3_valid) begin
                r_hb2_dl[0] <= r_y3;
                for (int i = 1; i < 6; i++) r_hb2_dl[i] <= r_hb2_dl[i-1];
                r_hb2_phase <= ~r_hb2_phase;
                if (r_hb2_phase) begin
                    r_out_data  <= OUTPUT_WIDTH'(w_hb2);
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_decimation_filter.sv
// Self-checking bench for decimation_filter: a kernel-level reference model of the cascade,
// a DC vector table, impulse / reset corner sequences and randomized gapped traffic.
module tb_decimation_filter;
    localparam int IW = 5;
    localparam int OW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [IW-1:0] in_data;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;

    always #5 clk = ~clk;

    decimation_filter #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     samples[$];      // accepted samples since the last reset
    int     exp_q[$];        // cycles at which out_valid is due
    longint exp_vals[$];     // model outputs issued so far
    longint out_vals[$];     // DUT outputs captured at pulses
    int     out_cycles[$];
    int     out_count;
    int     hcic[13];        // CIC impulse response: (1+z^-1+z^-2+z^-3)^4

    typedef struct {
        int     value;
        bit     gapped;
        longint exp_steady;
    } dc_vec_t;
    dc_vec_t vecs[4];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: the cascade as plain sums over the sample history ----------------
    function automatic longint m_y1(input int p);
        longint s = 0;
        if (p < 0) return 0;
        for (int j = 0; j < 13; j++) begin
            int idx = 4 * p + 3 - j;
            if (idx >= 0 && idx < samples.size()) s += longint'(hcic[j]) * samples[idx];
        end
        return s;
    endfunction

    function automatic longint m_y2(input int m);
        if (m < 0) return 0;
        return -m_y1(m) + 10 * m_y1(m - 1) - m_y1(m - 2);
    endfunction

    function automatic longint m_y3(input int k);
        int n = 2 * k + 1;
        if (k < 0) return 0;
        return -m_y2(n) + 9 * m_y2(n - 2) + 16 * m_y2(n - 3) + 9 * m_y2(n - 4) - m_y2(n - 6);
    endfunction

    function automatic longint m_y4(input int k);
        int n = 2 * k + 1;
        if (k < 0) return 0;
        return -m_y3(n) + 9 * m_y3(n - 2) + 16 * m_y3(n - 3) + 9 * m_y3(n - 4) - m_y3(n - 6);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit v, input int d);
        bit     exp_v;
        longint exp_d;
        in_valid = v;
        in_data  = IW'(d);
        @(posedge clk);
        cyc++;
        #1;
        if (v) begin
            samples.push_back(d);
            if (samples.size() % 16 == 0) exp_q.push_back(cyc + 4);
        end
        exp_v = (exp_q.size() > 0) && (exp_q[0] == cyc);
        check("out_valid", longint'(out_valid), longint'(exp_v));
        if (exp_v) begin
            void'(exp_q.pop_front());
            out_count++;
            exp_d = m_y4(out_count - 1);
            exp_vals.push_back(exp_d);
            out_vals.push_back(out_data);
            out_cycles.push_back(cyc);
            check($sformatf("out_data[%0d]", out_count), out_data, exp_d);
        end else begin
            check("out_data hold", out_data, (exp_vals.size() > 0) ? exp_vals[$] : 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'sd7;
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
            check("reset out_valid", longint'(out_valid), 0);
            check("reset out_data", out_data, 0);
        end
        rst = 1'b0;
        samples.delete();
        exp_q.delete();
        exp_vals.delete();
        out_vals.delete();
        out_cycles.delete();
        out_count = 0;
    endtask

    initial begin
        int p[13];
        int tmp[13];
        longint sum;

        vecs[0] = '{value:   1, gapped: 1'b0, exp_steady:   2097152};
        vecs[1] = '{value: -16, gapped: 1'b0, exp_steady: -33554432};
        vecs[2] = '{value:  15, gapped: 1'b0, exp_steady:  31457280};
        vecs[3] = '{value:   3, gapped: 1'b1, exp_steady:   6291456};

        p = '{default: 0};
        p[0] = 1;
        repeat (4) begin
            tmp = '{default: 0};
            for (int i = 0; i < 13; i++)
                for (int t = 0; t < 4; t++)
                    if (i + t < 13) tmp[i + t] += p[i];
            p = tmp;
        end
        hcic = p;

        rst = 1'b1; in_valid = 1'b0; in_data = '0;

        // Reset: clear after some traffic, hold 10 cycles with live input, then first output at #16.
        do_reset(2);
        for (int i = 0; i < 20; i++) step(1'b1, int'($urandom_range(0, 31)) - 16);
        do_reset(10);
        for (int i = 0; i < 16; i++) step(1'b1, 5);
        idle(6);
        check("reset: outputs after 16 samples", out_count, 1);

        // DC table: count, cadence and steady-state value.
        for (int v = 0; v < 4; v++) begin
            do_reset(2);
            if (vecs[v].gapped) for (int i = 0; i < 512; i++) step(i % 2 == 0, vecs[v].value);
            else                for (int i = 0; i < 256; i++) step(1'b1, vecs[v].value);
            idle(8);
            check($sformatf("dc%0d count", v), out_vals.size(), 16);
            for (int k = 8; k <= out_vals.size(); k++)
                check($sformatf("dc%0d steady[%0d]", v, k), out_vals[k - 1], vecs[v].exp_steady);
            for (int k = 2; k <= out_cycles.size(); k++)
                check($sformatf("dc%0d spacing[%0d]", v, k), out_cycles[k - 1] - out_cycles[k - 2],
                      vecs[v].gapped ? 32 : 16);
        end

        // Impulse: total equals 2^21/16 and the tail dies out by output #7.
        do_reset(2);
        for (int i = 0; i < 160; i++) step(1'b1, (i == 0) ? 1 : 0);
        idle(8);
        check("impulse count", out_vals.size(), 10);
        sum = 0;
        foreach (out_vals[i]) sum += out_vals[i];
        check("impulse sum", sum, 131072);
        for (int k = 7; k <= out_vals.size(); k++)
            check($sformatf("impulse tail[%0d]", k), out_vals[k - 1], 0);

        // Mid-stream reset, then a reset that kills an output already in flight.
        do_reset(2);
        for (int i = 0; i < 40; i++) step(1'b1, 2);
        do_reset(1);
        for (int i = 0; i < 18; i++) step(1'b1, 2);
        do_reset(1);
        idle(6);
        for (int i = 0; i < 32; i++) step(1'b1, 2);
        idle(8);
        check("post-reset count", out_count, 2);

        // Randomized data with random gaps against the model.
        do_reset(2);
        for (int i = 0; i < 800; i++) step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)) - 16);
        idle(8);
        check("random count", out_count, samples.size() / 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
